// File: rtl/fp_norm_round_28bit_if.sv
// Handshake bundle between the FP add/sub ALU stage and the normalize/round stage.
// master = upstream producer/downstream consumer side, slave = fp_norm_round_28bit.
interface fp_norm_round_28bit_if #(
  parameter int MANT_W = 28,
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
);
  logic                    in_valid;
  logic                    in_ready;
  logic [MANT_W-1:0]       mant_i;
  logic                    c_alu_i;
  logic                    aos_i;
  logic [EXP_W-1:0]        exp_i;
  logic                    sign_i;
  logic                    out_valid;
  logic                    out_ready;
  logic [EXP_W+FRAC_W:0]   result_o;
  logic                    ovf_o;
  logic                    unf_o;

  modport master (
    output in_valid, mant_i, c_alu_i, aos_i, exp_i, sign_i, out_ready,
    input  in_ready, out_valid, result_o, ovf_o, unf_o
  );

  modport slave (
    input  in_valid, mant_i, c_alu_i, aos_i, exp_i, sign_i, out_ready,
    output in_ready, out_valid, result_o, ovf_o, unf_o
  );
endinterface

// File: rtl/fp_norm_round_28bit.sv
// Post-ALU normalize + round-to-nearest-even + IEEE-754 single pack, valid/ready handshake.
// Define FPNR_LZC_EN to replace the one-bit-per-cycle NORM loop with a single-cycle LZC + barrel shift.
module fp_norm_round_28bit #(
  parameter int MANT_W = 28,
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                  clk,
  input  logic                  rst,
  fp_norm_round_28bit_if.slave  bus
);

  localparam int XW  = EXP_W + 2;   // headroom for the +1 increments past 255
  localparam int HID = FRAC_W + 3;  // hidden-bit position in the raw mantissa
  localparam int RW  = EXP_W + FRAC_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [MANT_W-1:0] mant_reg, mant_next;
  logic [XW-1:0]     exp_reg, exp_next;
  logic              sign_reg, sign_next;
  logic              aos_reg, aos_next;
  logic              c_alu_reg, c_alu_next;
  logic              zero_reg, zero_next;
  logic [RW-1:0]     result_reg, result_next;
  logic              ovf_reg, ovf_next;
  logic              unf_reg, unf_next;

  // PREP: sign fix-up of a borrowed subtraction
  logic              neg;
  logic [MANT_W-1:0] mant_fix;
  logic              prep_zero;
  logic              prep_to_norm;

  always_comb begin
    neg          = aos_reg & ~c_alu_reg;
    mant_fix     = neg ? (~mant_reg + {{(MANT_W-1){1'b0}}, 1'b1}) : mant_reg;
    prep_zero    = (mant_fix == '0);
    prep_to_norm = ~prep_zero & ~mant_fix[MANT_W-1] & ~mant_fix[HID] & (exp_reg > XW'(1));
  end

  logic [MANT_W-1:0] norm_mant;
  logic [XW-1:0]     norm_exp;
  logic              norm_exit;

`ifdef FPNR_LZC_EN
  // Shift by min(leading zeros above bit HID, exp-1) so denormal limits match the iterative loop
  logic [4:0]    lzc;
  logic [XW-1:0] norm_amt;
  logic [XW-1:0] exp_room;

  always_comb begin
    lzc = 5'd0;
    for (int i = 0; i < HID; i++) begin
      if (mant_reg[i]) begin
        lzc = 5'(HID - i);
      end
    end
    exp_room  = exp_reg - XW'(1);
    norm_amt  = (XW'(lzc) < exp_room) ? XW'(lzc) : exp_room;
    norm_mant = mant_reg << norm_amt;
    norm_exp  = exp_reg - norm_amt;
    norm_exit = 1'b1;
  end
`else
  always_comb begin
    norm_mant = mant_reg << 1;
    norm_exp  = exp_reg - XW'(1);
    norm_exit = norm_mant[HID] | (norm_exp == XW'(1));
  end
`endif

  // ROUND: RNE on G with sticky = R|S, tie broken by frac LSB
  logic              rnd_up;
  logic [FRAC_W+1:0] rnd_sum;
  logic              rnd_carry;
  logic [XW-1:0]     rnd_exp;
  logic [FRAC_W-1:0] rnd_frac;
  logic              rnd_hidden;

  always_comb begin
    rnd_up     = mant_reg[2] & (mant_reg[1] | mant_reg[0] | mant_reg[3]);
    rnd_sum    = {1'b0, mant_reg[HID:3]} + {{(FRAC_W+1){1'b0}}, rnd_up};
    rnd_carry  = rnd_sum[FRAC_W+1];
    rnd_exp    = exp_reg + {{(XW-1){1'b0}}, rnd_carry};
    rnd_frac   = rnd_carry ? rnd_sum[FRAC_W:1] : rnd_sum[FRAC_W-1:0];
    rnd_hidden = rnd_carry | rnd_sum[FRAC_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (bus.in_valid) state_next = S_PREP;
      S_PREP:  state_next = prep_to_norm ? S_NORM : S_ROUND;
      S_NORM:  if (norm_exit) state_next = S_ROUND;
      S_ROUND: state_next = S_DONE;
      S_DONE:  if (bus.out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    mant_next   = mant_reg;
    exp_next    = exp_reg;
    sign_next   = sign_reg;
    aos_next    = aos_reg;
    c_alu_next  = c_alu_reg;
    zero_next   = zero_reg;
    result_next = result_reg;
    ovf_next    = ovf_reg;
    unf_next    = unf_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.in_valid) begin
          mant_next  = bus.mant_i;
          // exponent 0 belongs to a denormal operand, which aligns as exponent 1
          exp_next   = (bus.exp_i == '0) ? XW'(1) : XW'(bus.exp_i);
          sign_next  = bus.sign_i;
          aos_next   = bus.aos_i;
          c_alu_next = bus.c_alu_i;
          zero_next  = 1'b0;
        end
      end
      S_PREP: begin
        mant_next = mant_fix;
        sign_next = sign_reg ^ neg;
        if (prep_zero) begin
          zero_next = 1'b1;
          sign_next = 1'b0;
        end else if (mant_fix[MANT_W-1]) begin
          mant_next = {1'b0, mant_fix[MANT_W-1:2], mant_fix[1] | mant_fix[0]};
          exp_next  = exp_reg + XW'(1);
        end
      end
      S_NORM: begin
        mant_next = norm_mant;
        exp_next  = norm_exp;
      end
      S_ROUND: begin
        if (zero_reg) begin
          result_next = '0;
          ovf_next    = 1'b0;
          unf_next    = 1'b0;
        end else if (rnd_exp >= XW'((1 << EXP_W) - 1)) begin
          result_next = {sign_reg, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
          ovf_next    = 1'b1;
          unf_next    = 1'b0;
        end else if (rnd_hidden) begin
          result_next = {sign_reg, rnd_exp[EXP_W-1:0], rnd_frac};
          ovf_next    = 1'b0;
          unf_next    = 1'b0;
        end else begin
          result_next = {sign_reg, {EXP_W{1'b0}}, rnd_frac};
          ovf_next    = 1'b0;
          unf_next    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mant_reg   <= '0;
      exp_reg    <= '0;
      sign_reg   <= 1'b0;
      aos_reg    <= 1'b0;
      c_alu_reg  <= 1'b0;
      zero_reg   <= 1'b0;
      result_reg <= '0;
      ovf_reg    <= 1'b0;
      unf_reg    <= 1'b0;
    end else begin
      mant_reg   <= mant_next;
      exp_reg    <= exp_next;
      sign_reg   <= sign_next;
      aos_reg    <= aos_next;
      c_alu_reg  <= c_alu_next;
      zero_reg   <= zero_next;
      result_reg <= result_next;
      ovf_reg    <= ovf_next;
      unf_reg    <= unf_next;
    end
  end

  always_comb begin
    bus.in_ready  = (state_reg == S_IDLE);
    bus.out_valid = (state_reg == S_DONE);
    bus.result_o  = result_reg;
    bus.ovf_o     = ovf_reg;
    bus.unf_o     = unf_reg;
  end

endmodule
